demux_tdm_1to4b4: RTL and testbench
===================================

# demux_tdm_1to4b4

Time-division demultiplexer that reverses the 4-to-1 nibble multiplexing on the receive side of a shared 4-bit link. It takes a serial stream of nibbles framed by a sync strobe and distributes slot 0..3 to four lane registers. All four lanes update together, so downstream logic always sees a coherent frame. It sits directly after the link input register and feeds the per-lane consumers.

## Interface
- W, default 4: lane and data width in bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- sync  input  1  frame-start marker; the nibble accepted in the same cycle belongs to slot 0.
- in_valid  input  1  in_data carries a nibble this cycle.
- in_data  input  W  incoming nibble.
- O0, O1, O2, O3  output  W  registered lane outputs; they hold the last complete frame.
- frame_valid  output  1  one-cycle pulse when O0..O3 have just been updated.
- slot  output  2  slot index the next accepted nibble will occupy.
- locked  output  1  high once framing has been acquired.
- err  output  1  short-frame flag; present only with DEMUX_TDM_ERR_EN.

## Operation
- State machine has two states:
  - HUNT: the reset state. Nibbles arriving without sync are discarded, and slot stays at 0.
  - LOCKED: entered when sync is seen in HUNT.
- Staging registers st0..st2 capture slots 0..2. Slot 3 is taken directly from in_data when the frame completes.
- Acceptance occurs when in_valid=1 and the block is LOCKED, or when sync=1.
- sync with in_valid=1:
  - in_data goes to st0 and slot becomes 1.
  - The block enters or stays in LOCKED.
  - Any partial frame is discarded, and no frame_valid is produced for it.
- sync with in_valid=0:
  - slot becomes 0 and the block enters LOCKED.
  - The partial frame is discarded.
- LOCKED with in_valid=1 and sync=0:
  - Slots 0..2 write st[slot] and increment slot.
  - Slot 3 commits: O0<=st0, O1<=st1, O2<=st2, O3<=in_data. frame_valid pulses, and slot wraps to 0.
- After the wrap the block stays LOCKED. The next frame may start with or without sync; free-running framing is allowed.
- Counting rules:
  - in_valid=0 cycles do not advance slot; gaps between nibbles are allowed.
  - slot is a 2-bit counter that wraps modulo 4.
- sync always overrides: sync at slot 3 with in_valid=1 starts a new frame instead of completing the current one.
- O0..O3 change only on a commit. Between commits they hold their value.

## Timing
- Reset values: O0..O3=0, frame_valid=0, slot=0, locked=0, err=0, st0..st2=0, state=HUNT.
- Reset is asynchronous. Asserting rst mid-frame immediately clears all of the above and drops any partial frame.
- Commit latency: the O0..O3 update and the frame_valid pulse appear on the clock edge that accepts slot 3. They are visible in the cycle after in_data is presented.
- frame_valid is high for exactly one cycle per commit.
- Back-to-back frames with in_valid held high produce one frame_valid every 4 cycles.
- slot and locked are registered and update on the same edge as the acceptance that changes them.

## Configuration
- DEMUX_TDM_ERR_EN defined:
  - The err output exists.
  - err pulses for one cycle, on the edge after a sync is seen while LOCKED with slot != 0, i.e. a short frame was dropped.
  - A sync arriving at slot 0 does not flag.
  - A sync in HUNT does not flag.
- DEMUX_TDM_ERR_EN undefined:
  - The err port and its logic are omitted.
  - Framing behaviour is otherwise identical.

## Test plan
- Reset, then in_valid=1 with in_data 5,6,7,8 and no sync -> all discarded; locked=0, slot=0, frame_valid never asserts, O0..O3=0.
- sync+in_valid with in_data 1, then 2,3,4 on consecutive cycles -> one cycle after the nibble 4, O0..O3=1,2,3,4, frame_valid=1 for one cycle, slot=0.
- Same frame 1,2,3,4 with an in_valid=0 cycle between each nibble -> identical result; slot counts 1,2,3,0 only on valid cycles.
- Frame A,B then sync+in_valid with C, followed by D,E,F -> no commit for the A,B frame; O=C,D,E,F; with DEMUX_TDM_ERR_EN defined, err pulses once on the edge after the C sync.
- Two frames 1..4 then 9..C back-to-back, sync only on the first -> frame_valid every 4 cycles; O=1,2,3,4 and then 9,A,B,C.
- rst asserted asynchronously after slot 2 of a frame -> outputs and slot read 0 immediately and locked=0; the next nibbles are ignored until sync.

Source files
------------

// File: rtl/demux_tdm_1to4b4_if.sv
// rtl/demux_tdm_1to4b4_if.sv - link-side nibble stream and lane outputs of the 1-to-4 TDM demux
// The err member exists only when DEMUX_TDM_ERR_EN is defined.
interface demux_tdm_1to4b4_if #(
  parameter int W = 4
);
  logic         sync;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic [W-1:0] O0;
  logic [W-1:0] O1;
  logic [W-1:0] O2;
  logic [W-1:0] O3;
  logic         frame_valid;
  logic [1:0]   slot;
  logic         locked;
`ifdef DEMUX_TDM_ERR_EN
  logic         err;

  modport master (
    output sync, in_valid, in_data,
    input  O0, O1, O2, O3, frame_valid, slot, locked, err
  );
  modport slave (
    input  sync, in_valid, in_data,
    output O0, O1, O2, O3, frame_valid, slot, locked, err
  );
`else
  modport master (
    output sync, in_valid, in_data,
    input  O0, O1, O2, O3, frame_valid, slot, locked
  );
  modport slave (
    input  sync, in_valid, in_data,
    output O0, O1, O2, O3, frame_valid, slot, locked
  );
`endif
endinterface

// File: rtl/demux_tdm_1to4b4.sv
// rtl/demux_tdm_1to4b4.sv - 1-to-4 nibble TDM demultiplexer with sync framing and coherent lane commit
// Optional short-frame flag err is built when DEMUX_TDM_ERR_EN is defined.
module demux_tdm_1to4b4 #(
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst,
  demux_tdm_1to4b4_if.slave  bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t       state_q, state_d;
  logic [1:0]   slot_q, slot_d;
  logic [W-1:0] st0_q, st0_d;
  logic [W-1:0] st1_q, st1_d;
  logic [W-1:0] st2_q, st2_d;
  logic [W-1:0] o0_q, o0_d;
  logic [W-1:0] o1_q, o1_d;
  logic [W-1:0] o2_q, o2_d;
  logic [W-1:0] o3_q, o3_d;
  logic         fv_q, fv_d;
`ifdef DEMUX_TDM_ERR_EN
  logic         err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    st0_d   = st0_q;
    st1_d   = st1_q;
    st2_d   = st2_q;
    o0_d    = o0_q;
    o1_d    = o1_q;
    o2_d    = o2_q;
    o3_d    = o3_q;
    fv_d    = 1'b0;
`ifdef DEMUX_TDM_ERR_EN
    err_d   = 1'b0;
`endif
    if (bus.sync) begin
      // sync restarts framing; any partially collected frame is simply abandoned
      state_d = LOCKED;
`ifdef DEMUX_TDM_ERR_EN
      err_d = (state_q == LOCKED) && (slot_q != 2'd0);
`endif
      if (bus.in_valid) begin
        st0_d  = bus.in_data;
        slot_d = 2'd1;
      end else begin
        slot_d = 2'd0;
      end
    end else if ((state_q == LOCKED) && bus.in_valid) begin
      slot_d = slot_q + 2'd1;
      case (slot_q)
        2'd0: st0_d = bus.in_data;
        2'd1: st1_d = bus.in_data;
        2'd2: st2_d = bus.in_data;
        2'd3: begin
          // slot 3 bypasses staging so all four lanes land on the same edge
          o0_d = st0_q;
          o1_d = st1_q;
          o2_d = st2_q;
          o3_d = bus.in_data;
          fv_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      st0_q   <= '0;
      st1_q   <= '0;
      st2_q   <= '0;
      o0_q    <= '0;
      o1_q    <= '0;
      o2_q    <= '0;
      o3_q    <= '0;
      fv_q    <= 1'b0;
`ifdef DEMUX_TDM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      st0_q   <= st0_d;
      st1_q   <= st1_d;
      st2_q   <= st2_d;
      o0_q    <= o0_d;
      o1_q    <= o1_d;
      o2_q    <= o2_d;
      o3_q    <= o3_d;
      fv_q    <= fv_d;
`ifdef DEMUX_TDM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.O0          = o0_q;
  assign bus.O1          = o1_q;
  assign bus.O2          = o2_q;
  assign bus.O3          = o3_q;
  assign bus.frame_valid = fv_q;
  assign bus.slot        = slot_q;
  assign bus.locked      = (state_q == LOCKED);
`ifdef DEMUX_TDM_ERR_EN
  assign bus.err         = err_q;
`endif

endmodule

// File: tb/tb_demux_tdm_1to4b4.sv
// tb/tb_demux_tdm_1to4b4.sv - directed self-checking bench for demux_tdm_1to4b4
module tb_demux_tdm_1to4b4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  demux_tdm_1to4b4_if #(.W(4)) bus ();

  demux_tdm_1to4b4 #(.W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [3:0] d);
    bus.sync     = s;
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lanes();
    return {bus.O0, bus.O1, bus.O2, bus.O3};
  endfunction

  initial begin
    bus.sync     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lanes", lanes(), 16'h0000);
    chk("rst_fv", {15'd0, bus.frame_valid}, 16'd0);
    chk("rst_slot", {14'd0, bus.slot}, 16'd0);
    chk("rst_locked", {15'd0, bus.locked}, 16'd0);
`ifdef DEMUX_TDM_ERR_EN
    chk("rst_err", {15'd0, bus.err}, 16'd0);
`endif
    rst = 1'b0;

    // no sync: everything discarded
    for (int i = 5; i <= 8; i++) begin
      step(1'b0, 1'b1, 4'(i));
      chk("hunt_locked", {15'd0, bus.locked}, 16'd0);
      chk("hunt_slot", {14'd0, bus.slot}, 16'd0);
      chk("hunt_fv", {15'd0, bus.frame_valid}, 16'd0);
    end
    chk("hunt_lanes", lanes(), 16'h0000);

    // synced frame 1,2,3,4
    step(1'b1, 1'b1, 4'h1);
    chk("f1_slot1", {14'd0, bus.slot}, 16'd1);
    chk("f1_locked", {15'd0, bus.locked}, 16'd1);
    step(1'b0, 1'b1, 4'h2);
    chk("f1_slot2", {14'd0, bus.slot}, 16'd2);
    step(1'b0, 1'b1, 4'h3);
    chk("f1_slot3", {14'd0, bus.slot}, 16'd3);
    chk("f1_fv_early", {15'd0, bus.frame_valid}, 16'd0);
    chk("f1_lanes_early", lanes(), 16'h0000);
    step(1'b0, 1'b1, 4'h4);
    chk("f1_fv", {15'd0, bus.frame_valid}, 16'd1);
    chk("f1_lanes", lanes(), 16'h1234);
    chk("f1_slot0", {14'd0, bus.slot}, 16'd0);
    step(1'b0, 1'b0, 4'hF);
    chk("f1_fv_pulse", {15'd0, bus.frame_valid}, 16'd0);
    chk("f1_hold", lanes(), 16'h1234);

    // same frame with idle gaps
    step(1'b1, 1'b1, 4'h1);
    chk("g_slot1", {14'd0, bus.slot}, 16'd1);
    step(1'b0, 1'b0, 4'h9);
    chk("g_gap1", {14'd0, bus.slot}, 16'd1);
    step(1'b0, 1'b1, 4'h2);
    chk("g_slot2", {14'd0, bus.slot}, 16'd2);
    step(1'b0, 1'b0, 4'h9);
    chk("g_gap2", {14'd0, bus.slot}, 16'd2);
    step(1'b0, 1'b1, 4'h3);
    chk("g_slot3", {14'd0, bus.slot}, 16'd3);
    step(1'b0, 1'b0, 4'h9);
    chk("g_gap3", {14'd0, bus.slot}, 16'd3);
    chk("g_gap3_fv", {15'd0, bus.frame_valid}, 16'd0);
    step(1'b0, 1'b1, 4'h4);
    chk("g_fv", {15'd0, bus.frame_valid}, 16'd1);
    chk("g_lanes", lanes(), 16'h1234);
    chk("g_slot0", {14'd0, bus.slot}, 16'd0);

    // A,B free-running then sync C overrides: C,D,E,F commits
    step(1'b0, 1'b1, 4'hA);
    chk("s_slot1", {14'd0, bus.slot}, 16'd1);
    step(1'b0, 1'b1, 4'hB);
    chk("s_slot2", {14'd0, bus.slot}, 16'd2);
    step(1'b1, 1'b1, 4'hC);
    chk("s_resync_slot", {14'd0, bus.slot}, 16'd1);
    chk("s_resync_fv", {15'd0, bus.frame_valid}, 16'd0);
    chk("s_resync_hold", lanes(), 16'h1234);
`ifdef DEMUX_TDM_ERR_EN
    chk("s_err_pulse", {15'd0, bus.err}, 16'd1);
`endif
    step(1'b0, 1'b1, 4'hD);
`ifdef DEMUX_TDM_ERR_EN
    chk("s_err_clear", {15'd0, bus.err}, 16'd0);
`endif
    step(1'b0, 1'b1, 4'hE);
    chk("s_slot3", {14'd0, bus.slot}, 16'd3);
    step(1'b0, 1'b1, 4'hF);
    chk("s_fv", {15'd0, bus.frame_valid}, 16'd1);
    chk("s_lanes", lanes(), 16'hCDEF);

    // back-to-back frames, sync on first only (sync at slot 0 must not flag)
    step(1'b1, 1'b1, 4'h1);
    chk("b_fv_1", {15'd0, bus.frame_valid}, 16'd0);
`ifdef DEMUX_TDM_ERR_EN
    chk("b_no_err", {15'd0, bus.err}, 16'd0);
`endif
    step(1'b0, 1'b1, 4'h2);
    chk("b_fv_2", {15'd0, bus.frame_valid}, 16'd0);
    step(1'b0, 1'b1, 4'h3);
    chk("b_fv_3", {15'd0, bus.frame_valid}, 16'd0);
    step(1'b0, 1'b1, 4'h4);
    chk("b_fv_4", {15'd0, bus.frame_valid}, 16'd1);
    chk("b_lanes_a", lanes(), 16'h1234);
    step(1'b0, 1'b1, 4'h9);
    chk("b_fv_9", {15'd0, bus.frame_valid}, 16'd0);
    chk("b_hold_a", lanes(), 16'h1234);
    step(1'b0, 1'b1, 4'hA);
    chk("b_fv_a", {15'd0, bus.frame_valid}, 16'd0);
    step(1'b0, 1'b1, 4'hB);
    chk("b_fv_b", {15'd0, bus.frame_valid}, 16'd0);
    step(1'b0, 1'b1, 4'hC);
    chk("b_fv_c", {15'd0, bus.frame_valid}, 16'd1);
    chk("b_lanes_b", lanes(), 16'h9ABC);

    // asynchronous reset mid-frame
    step(1'b1, 1'b1, 4'h5);
    step(1'b0, 1'b1, 4'h6);
    chk("r_pre_slot", {14'd0, bus.slot}, 16'd2);
    bus.in_valid = 1'b0;
    bus.sync     = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("r_lanes", lanes(), 16'h0000);
    chk("r_slot", {14'd0, bus.slot}, 16'd0);
    chk("r_locked", {15'd0, bus.locked}, 16'd0);
    chk("r_fv", {15'd0, bus.frame_valid}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 4'h7);
    chk("r_ign_slot", {14'd0, bus.slot}, 16'd0);
    chk("r_ign_locked", {15'd0, bus.locked}, 16'd0);
    step(1'b0, 1'b1, 4'h8);
    chk("r_ign_slot2", {14'd0, bus.slot}, 16'd0);
    step(1'b1, 1'b0, 4'h0);
    chk("r_sync_locked", {15'd0, bus.locked}, 16'd1);
    chk("r_sync_slot", {14'd0, bus.slot}, 16'd0);
    step(1'b0, 1'b1, 4'h1);
    chk("r_after_slot", {14'd0, bus.slot}, 16'd1);
    chk("r_after_lanes", lanes(), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
